// File: rtl/bp_fe_cmd_handler_pkg.sv
// bp_fe_cmd_handler_pkg: processor config, fe_cmd packet layout, decode effect vector and FSM states
package bp_fe_cmd_handler_pkg;

    typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

    typedef struct packed {
        int vaddr_width;
        int paddr_width;
        int asid_width;
        int branch_metadata_fwd_width;
    } bp_proc_param_s;

    function automatic bp_proc_param_s bp_proc_param(bp_params_e cfg);
        return (cfg == e_bp_default_cfg) ? bp_proc_param_s'{39, 56, 1, 32} : bp_proc_param_s'('0);
    endfunction

    // Packet structs below are laid out for the default configuration.
    localparam bp_proc_param_s default_param_gp = bp_proc_param(e_bp_default_cfg);
    localparam int vaddr_width_gp = default_param_gp.vaddr_width;
    localparam int ptag_width_gp = default_param_gp.paddr_width - 12;
    localparam int branch_metadata_fwd_width_gp = default_param_gp.branch_metadata_fwd_width;

    typedef enum logic [2:0] {
        e_op_state_reset, e_op_pc_redirection, e_op_attaboy, e_op_icache_fill,
        e_op_icache_fence, e_op_itlb_fill, e_op_itlb_fence, e_op_wait
    } bp_fe_command_queue_opcodes_e;

    typedef enum logic [2:0] {
        e_subop_eret, e_subop_interrupt, e_subop_branch_mispredict,
        e_subop_trap, e_subop_translation_switch, e_subop_resume
    } bp_fe_command_queue_subopcodes_e;

    typedef enum logic [1:0] {
        e_not_a_branch, e_incorrect_pred_taken, e_incorrect_pred_ntaken
    } bp_fe_misprediction_reason_e;

    typedef struct packed {
        logic [ptag_width_gp-1:0] ptag;
        logic g;
        logic u;
        logic x;
        logic w;
        logic r;
    } bp_pte_leaf_s;

    localparam int pte_leaf_width_gp = $bits(bp_pte_leaf_s);

    typedef struct packed {
        bp_fe_command_queue_opcodes_e opcode;
        logic [vaddr_width_gp-1:0] npc;
        bp_fe_command_queue_subopcodes_e subopcode;
        bp_fe_misprediction_reason_e misprediction_reason;
        logic [branch_metadata_fwd_width_gp-1:0] branch_metadata_fwd;
        logic attaboy_taken;
        logic [1:0] priv;
        logic translation_en;
        bp_pte_leaf_s pte_leaf;
    } bp_fe_cmd_s;

    localparam int fe_cmd_width_gp = $bits(bp_fe_cmd_s);

    typedef struct packed {
        logic state_reset;
        logic redirect;
        logic br;
        logic br_taken;
        logic br_ntaken;
        logic br_nonbr;
        logic load_priv;
        logic load_tran;
        logic attaboy;
        logic itlb_w;
        logic itlb_fence;
        logic icache_fence;
        logic wait_cmd;
    } bp_fe_cmd_effect_s;

    typedef enum logic [1:0] {e_reset, e_run, e_fence, e_wait} bp_fe_cmd_state_e;

endpackage

// File: rtl/bp_fe_cmd_handler_if.sv
// bp_fe_cmd_handler_if: BE->FE command queue handshake (packet, valid, yumi)
interface bp_fe_cmd_handler_if;
    import bp_fe_cmd_handler_pkg::*;
    bp_fe_cmd_s fe_cmd;
    logic fe_cmd_v;
    logic fe_cmd_yumi;
    modport master (output fe_cmd, fe_cmd_v, input fe_cmd_yumi);
    modport slave (input fe_cmd, fe_cmd_v, output fe_cmd_yumi);
endinterface

// File: rtl/bp_fe_cmd_decode.sv
// bp_fe_cmd_decode: combinational opcode/subopcode/reason -> front-end effect vector
// opcode_i, subopcode_i, reason_i: command fields; effect_o: side effects the command requests
module bp_fe_cmd_decode
    import bp_fe_cmd_handler_pkg::*;
(
    input  bp_fe_command_queue_opcodes_e    opcode_i,
    input  bp_fe_command_queue_subopcodes_e subopcode_i,
    input  bp_fe_misprediction_reason_e     reason_i,
    output bp_fe_cmd_effect_s               effect_o
);
    logic mispredict, priv_switch;

    always_comb begin
        mispredict = subopcode_i == e_subop_branch_mispredict;
        priv_switch = subopcode_i inside {e_subop_resume, e_subop_eret, e_subop_trap, e_subop_interrupt};
        effect_o = '0;
        case (opcode_i)
            e_op_state_reset: begin
                effect_o.state_reset = 1'b1;
                effect_o.redirect = 1'b1;
                effect_o.load_priv = 1'b1;
                effect_o.load_tran = 1'b1;
            end
            e_op_pc_redirection: begin
                effect_o.redirect = 1'b1;
                effect_o.load_priv = priv_switch;
                effect_o.load_tran = priv_switch || subopcode_i == e_subop_translation_switch;
                effect_o.br = mispredict;
                effect_o.br_taken = mispredict && reason_i == e_incorrect_pred_taken;
                effect_o.br_ntaken = mispredict && reason_i == e_incorrect_pred_ntaken;
                effect_o.br_nonbr = mispredict && reason_i == e_not_a_branch;
            end
            e_op_attaboy: effect_o.attaboy = 1'b1;
            e_op_icache_fill: effect_o.redirect = 1'b1;
            e_op_icache_fence: effect_o.icache_fence = 1'b1;
            e_op_itlb_fill: begin
                effect_o.itlb_w = 1'b1;
                effect_o.redirect = 1'b1;
            end
            e_op_itlb_fence: begin
                effect_o.itlb_fence = 1'b1;
                effect_o.redirect = 1'b1;
            end
            e_op_wait: effect_o.wait_cmd = 1'b1;
        endcase
    end
endmodule

// File: rtl/bp_fe_cmd_handler.sv
// bp_fe_cmd_handler: dequeues BE->FE commands and issues registered one-cycle FE side-effect pulses
// clk_i/reset_i: clock, sync active-high reset; fe_cmd_if: command queue (slave side)
// icache_fence_done_i: I$ fence complete; redirect_*/attaboy_*: PC-gen and predictor pulses
// priv_o/translation_en_o: persistent state; itlb_*/icache_fence_v_o: TLB/cache pulses
// fetch_stall_o: fetch must not issue this cycle
module bp_fe_cmd_handler
    import bp_fe_cmd_handler_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    localparam bp_proc_param_s proc_param_lp = bp_proc_param(bp_params_p),
    localparam int vaddr_width_p = proc_param_lp.vaddr_width,
    localparam int branch_metadata_fwd_width_p = proc_param_lp.branch_metadata_fwd_width
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    bp_fe_cmd_handler_if.slave                     fe_cmd_if,
    input  logic                                   icache_fence_done_i,
    output logic                                   redirect_v_o,
    output logic [vaddr_width_p-1:0]               redirect_pc_o,
    output logic                                   redirect_br_v_o,
    output logic                                   redirect_br_taken_o,
    output logic                                   redirect_br_ntaken_o,
    output logic                                   redirect_br_nonbr_o,
    output logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o,
    output logic                                   attaboy_v_o,
    output logic                                   attaboy_taken_o,
    output logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o,
    output logic [1:0]                             priv_o,
    output logic                                   translation_en_o,
    output logic                                   itlb_w_v_o,
    output logic [vaddr_width_p-1:0]               itlb_w_vaddr_o,
    output logic [pte_leaf_width_gp-1:0]           itlb_w_pte_o,
    output logic                                   itlb_fence_v_o,
    output logic                                   icache_fence_v_o,
    output logic                                   fetch_stall_o
);
    typedef struct packed {
        logic                                   redirect_v;
        logic [vaddr_width_p-1:0]               redirect_pc;
        logic                                   br_v;
        logic                                   br_taken;
        logic                                   br_ntaken;
        logic                                   br_nonbr;
        logic [branch_metadata_fwd_width_p-1:0] br_md;
        logic                                   attaboy_v;
        logic                                   attaboy_taken;
        logic [branch_metadata_fwd_width_p-1:0] attaboy_md;
        logic                                   itlb_w_v;
        logic [vaddr_width_p-1:0]               itlb_w_vaddr;
        logic [pte_leaf_width_gp-1:0]           itlb_w_pte;
        logic                                   itlb_fence_v;
        logic                                   icache_fence_v;
    } pulse_s;

    bp_fe_cmd_state_e state_q, state_d;
    pulse_s pulse_q, pulse_d;
    logic [1:0] priv_q, priv_d;
    logic tran_q, tran_d;
    logic [vaddr_width_p-1:0] fence_npc_q, fence_npc_d;
    bp_fe_cmd_s cmd;
    bp_fe_cmd_effect_s eff;
    logic act, fence_done, redirect;

    assign cmd = fe_cmd_if.fe_cmd;

    bp_fe_cmd_decode decode (
        .opcode_i    (cmd.opcode),
        .subopcode_i (cmd.subopcode),
        .reason_i    (cmd.misprediction_reason),
        .effect_o    (eff)
    );

    // Everything is dequeued outside e_fence; in e_reset only state_reset acts, the rest is dropped.
    assign fe_cmd_if.fe_cmd_yumi = fe_cmd_if.fe_cmd_v && state_q != e_fence;

    always_comb begin
        act = fe_cmd_if.fe_cmd_v && (state_q == e_run || state_q == e_wait || (state_q == e_reset && eff.state_reset));
        fence_done = state_q == e_fence && icache_fence_done_i;
        redirect = act && eff.redirect;
        state_d = fence_done ? e_run : !act ? state_q : eff.icache_fence ? e_fence : eff.wait_cmd ? e_wait : e_run;
        priv_d = act && eff.load_priv ? cmd.priv : priv_q;
        tran_d = act && eff.load_tran ? cmd.translation_en : tran_q;
        fence_npc_d = act && eff.icache_fence ? cmd.npc : fence_npc_q;
        pulse_d = '0;
        pulse_d.redirect_v = redirect || fence_done;
        pulse_d.redirect_pc = fence_done ? fence_npc_q : redirect ? cmd.npc : '0;
        pulse_d.br_v = act && eff.br;
        pulse_d.br_taken = act && eff.br_taken;
        pulse_d.br_ntaken = act && eff.br_ntaken;
        pulse_d.br_nonbr = act && eff.br_nonbr;
        pulse_d.br_md = pulse_d.br_v ? cmd.branch_metadata_fwd : '0;
        pulse_d.attaboy_v = act && eff.attaboy;
        pulse_d.attaboy_taken = pulse_d.attaboy_v && cmd.attaboy_taken;
        pulse_d.attaboy_md = pulse_d.attaboy_v ? cmd.branch_metadata_fwd : '0;
        pulse_d.itlb_w_v = act && eff.itlb_w;
        pulse_d.itlb_w_vaddr = pulse_d.itlb_w_v ? cmd.npc : '0;
        pulse_d.itlb_w_pte = pulse_d.itlb_w_v ? cmd.pte_leaf : '0;
        pulse_d.itlb_fence_v = act && eff.itlb_fence;
        pulse_d.icache_fence_v = act && eff.icache_fence;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_reset;
            pulse_q <= '0;
            priv_q <= 2'b11;
            tran_q <= 1'b0;
            fence_npc_q <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            priv_q <= priv_d;
            tran_q <= tran_d;
            fence_npc_q <= fence_npc_d;
        end
    end

    assign redirect_v_o = pulse_q.redirect_v;
    assign redirect_pc_o = pulse_q.redirect_pc;
    assign redirect_br_v_o = pulse_q.br_v;
    assign redirect_br_taken_o = pulse_q.br_taken;
    assign redirect_br_ntaken_o = pulse_q.br_ntaken;
    assign redirect_br_nonbr_o = pulse_q.br_nonbr;
    assign redirect_br_metadata_fwd_o = pulse_q.br_md;
    assign attaboy_v_o = pulse_q.attaboy_v;
    assign attaboy_taken_o = pulse_q.attaboy_taken;
    assign attaboy_br_metadata_fwd_o = pulse_q.attaboy_md;
    assign priv_o = priv_q;
    assign translation_en_o = tran_q;
    assign itlb_w_v_o = pulse_q.itlb_w_v;
    assign itlb_w_vaddr_o = pulse_q.itlb_w_vaddr;
    assign itlb_w_pte_o = pulse_q.itlb_w_pte;
    assign itlb_fence_v_o = pulse_q.itlb_fence_v;
    assign icache_fence_v_o = pulse_q.icache_fence_v;
    assign fetch_stall_o = state_q != e_run || pulse_q.redirect_v || pulse_q.itlb_fence_v || pulse_q.icache_fence_v;
endmodule

// File: tb/tb_bp_fe_cmd_handler.sv
// tb_bp_fe_cmd_handler: directed self-checking bench for bp_fe_cmd_handler
module tb_bp_fe_cmd_handler;
    import bp_fe_cmd_handler_pkg::*;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic icache_fence_done_i = 1'b0;
    logic redirect_v_o, redirect_br_v_o, redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o;
    logic [vaddr_width_gp-1:0] redirect_pc_o, itlb_w_vaddr_o;
    logic [branch_metadata_fwd_width_gp-1:0] redirect_br_metadata_fwd_o, attaboy_br_metadata_fwd_o;
    logic attaboy_v_o, attaboy_taken_o, translation_en_o, itlb_w_v_o, itlb_fence_v_o, icache_fence_v_o, fetch_stall_o;
    logic [1:0] priv_o;
    logic [pte_leaf_width_gp-1:0] itlb_w_pte_o;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_fe_cmd_handler_if fe_cmd_if();

    bp_fe_cmd_handler dut (
        .clk_i                      (clk),
        .reset_i                    (reset_i),
        .fe_cmd_if                  (fe_cmd_if),
        .icache_fence_done_i        (icache_fence_done_i),
        .redirect_v_o               (redirect_v_o),
        .redirect_pc_o              (redirect_pc_o),
        .redirect_br_v_o            (redirect_br_v_o),
        .redirect_br_taken_o        (redirect_br_taken_o),
        .redirect_br_ntaken_o       (redirect_br_ntaken_o),
        .redirect_br_nonbr_o        (redirect_br_nonbr_o),
        .redirect_br_metadata_fwd_o (redirect_br_metadata_fwd_o),
        .attaboy_v_o                (attaboy_v_o),
        .attaboy_taken_o            (attaboy_taken_o),
        .attaboy_br_metadata_fwd_o  (attaboy_br_metadata_fwd_o),
        .priv_o                     (priv_o),
        .translation_en_o           (translation_en_o),
        .itlb_w_v_o                 (itlb_w_v_o),
        .itlb_w_vaddr_o             (itlb_w_vaddr_o),
        .itlb_w_pte_o               (itlb_w_pte_o),
        .itlb_fence_v_o             (itlb_fence_v_o),
        .icache_fence_v_o           (icache_fence_v_o),
        .fetch_stall_o              (fetch_stall_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bp_fe_cmd_s mk(bp_fe_command_queue_opcodes_e op, logic [vaddr_width_gp-1:0] npc);
        bp_fe_cmd_s c;
        c = '0;
        c.opcode = op;
        c.npc = npc;
        return c;
    endfunction

    task automatic send(bp_fe_cmd_s c);
        fe_cmd_if.fe_cmd = c;
        fe_cmd_if.fe_cmd_v = 1'b1;
        tick;
        fe_cmd_if.fe_cmd_v = 1'b0;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        repeat (3) tick;
        reset_i = 1'b0;
        checks++;
        if ({redirect_v_o, redirect_br_v_o, attaboy_v_o, itlb_w_v_o, itlb_fence_v_o, icache_fence_v_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b want 000000", {redirect_v_o, redirect_br_v_o, attaboy_v_o, itlb_w_v_o, itlb_fence_v_o, icache_fence_v_o});
        end
        checks++;
        if ({priv_o, translation_en_o, fetch_stall_o, fe_cmd_if.fe_cmd_yumi} !== 5'b11010) begin
            errors++;
            $display("FAIL reset_state_outs: got %b want 11010", {priv_o, translation_en_o, fetch_stall_o, fe_cmd_if.fe_cmd_yumi});
        end
        checks++;
        if (redirect_pc_o !== '0 || dut.state_q !== e_reset) begin
            errors++;
            $display("FAIL reset_pc_state: got pc %h state %0d want 0 / %0d", redirect_pc_o, dut.state_q, e_reset);
        end
    endtask

    task automatic test_drop_in_reset;
        bp_fe_cmd_s c;
        c = mk(e_op_pc_redirection, 'h1234);
        c.subopcode = e_subop_resume;
        c.priv = 2'b00;
        c.translation_en = 1'b1;
        fe_cmd_if.fe_cmd = c;
        fe_cmd_if.fe_cmd_v = 1'b1;
        #1;
        checks++;
        if (fe_cmd_if.fe_cmd_yumi !== 1'b1) begin
            errors++;
            $display("FAIL drop_yumi: got %b want 1", fe_cmd_if.fe_cmd_yumi);
        end
        tick;
        fe_cmd_if.fe_cmd_v = 1'b0;
        checks++;
        if ({redirect_v_o, priv_o, translation_en_o, fetch_stall_o} !== 5'b01101 || dut.state_q !== e_reset) begin
            errors++;
            $display("FAIL drop_effect: got %b state %0d want 01101 state %0d", {redirect_v_o, priv_o, translation_en_o, fetch_stall_o}, dut.state_q, e_reset);
        end
    endtask

    task automatic test_state_reset;
        bp_fe_cmd_s c;
        c = mk(e_op_state_reset, 'h8000_0000);
        c.priv = 2'b11;
        send(c);
        checks++;
        if ({redirect_v_o, redirect_br_v_o, fetch_stall_o} !== 3'b101 || redirect_pc_o !== 'h8000_0000) begin
            errors++;
            $display("FAIL state_reset_redirect: got %b pc %h want 101 pc 80000000", {redirect_v_o, redirect_br_v_o, fetch_stall_o}, redirect_pc_o);
        end
        checks++;
        if (dut.state_q !== e_run) begin
            errors++;
            $display("FAIL state_reset_state: got %0d want %0d", dut.state_q, e_run);
        end
        tick;
        checks++;
        if ({redirect_v_o, fetch_stall_o} !== 2'b00) begin
            errors++;
            $display("FAIL state_reset_one_cycle: got %b want 00", {redirect_v_o, fetch_stall_o});
        end
    endtask

    task automatic test_priv;
        bp_fe_cmd_s c;
        c = mk(e_op_pc_redirection, 'h100);
        c.subopcode = e_subop_resume;
        c.priv = 2'b00;
        c.translation_en = 1'b1;
        send(c);
        checks++;
        if ({redirect_v_o, priv_o, translation_en_o} !== 4'b1001 || redirect_pc_o !== 'h100) begin
            errors++;
            $display("FAIL resume: got %b pc %h want 1001 pc 100", {redirect_v_o, priv_o, translation_en_o}, redirect_pc_o);
        end
        c = mk(e_op_pc_redirection, 'h200);
        c.subopcode = e_subop_translation_switch;
        c.priv = 2'b01;
        c.translation_en = 1'b0;
        send(c);
        checks++;
        if ({redirect_v_o, priv_o, translation_en_o} !== 4'b1000 || redirect_pc_o !== 'h200) begin
            errors++;
            $display("FAIL translation_switch: got %b pc %h want 1000 pc 200", {redirect_v_o, priv_o, translation_en_o}, redirect_pc_o);
        end
    endtask

    task automatic test_mispredict;
        bp_fe_cmd_s c;
        c = mk(e_op_pc_redirection, 'h1004);
        c.subopcode = e_subop_branch_mispredict;
        c.misprediction_reason = e_incorrect_pred_taken;
        c.branch_metadata_fwd = 32'hDEAD_BEEF;
        send(c);
        checks++;
        if ({redirect_v_o, redirect_br_v_o, redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o} !== 5'b11100
            || redirect_pc_o !== 'h1004 || redirect_br_metadata_fwd_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mispredict_taken: got %b pc %h md %h want 11100 pc 1004 md deadbeef",
                {redirect_v_o, redirect_br_v_o, redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o}, redirect_pc_o, redirect_br_metadata_fwd_o);
        end
        tick;
        checks++;
        if ({redirect_v_o, redirect_br_v_o, redirect_br_taken_o} !== 3'b000 || redirect_br_metadata_fwd_o !== '0) begin
            errors++;
            $display("FAIL mispredict_one_cycle: got %b md %h want 000 md 0", {redirect_v_o, redirect_br_v_o, redirect_br_taken_o}, redirect_br_metadata_fwd_o);
        end
        c.misprediction_reason = e_not_a_branch;
        send(c);
        checks++;
        if ({redirect_v_o, redirect_br_v_o, redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o} !== 5'b11001) begin
            errors++;
            $display("FAIL mispredict_nonbr: got %b want 11001", {redirect_v_o, redirect_br_v_o, redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o});
        end
        c.misprediction_reason = e_incorrect_pred_ntaken;
        send(c);
        checks++;
        if ({redirect_v_o, redirect_br_v_o, redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o} !== 5'b11010) begin
            errors++;
            $display("FAIL mispredict_ntaken: got %b want 11010", {redirect_v_o, redirect_br_v_o, redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o});
        end
    endtask

    task automatic test_back_to_back;
        bp_fe_cmd_s c;
        logic taken;
        for (int i = 0; i < 3; i++) begin
            taken = (i != 1);
            c = mk(e_op_attaboy, '0);
            c.attaboy_taken = taken;
            c.branch_metadata_fwd = 32'(i + 1);
            fe_cmd_if.fe_cmd = c;
            fe_cmd_if.fe_cmd_v = 1'b1;
            tick;
            checks++;
            if ({attaboy_v_o, attaboy_taken_o, redirect_v_o, fe_cmd_if.fe_cmd_yumi} !== {1'b1, taken, 1'b0, 1'b1}
                || attaboy_br_metadata_fwd_o !== 32'(i + 1)) begin
                errors++;
                $display("FAIL attaboy_%0d: got %b md %h want %b md %h", i, {attaboy_v_o, attaboy_taken_o, redirect_v_o, fe_cmd_if.fe_cmd_yumi},
                    attaboy_br_metadata_fwd_o, {1'b1, taken, 1'b0, 1'b1}, 32'(i + 1));
            end
        end
        fe_cmd_if.fe_cmd_v = 1'b0;
        tick;
        checks++;
        if (attaboy_v_o !== 1'b0) begin
            errors++;
            $display("FAIL attaboy_end: got %b want 0", attaboy_v_o);
        end
    endtask

    task automatic test_itlb;
        bp_fe_cmd_s c;
        c = mk(e_op_itlb_fill, 'h4000_1000);
        c.pte_leaf.ptag = 44'h12345;
        c.pte_leaf.x = 1'b1;
        c.pte_leaf.r = 1'b1;
        send(c);
        checks++;
        if ({itlb_w_v_o, redirect_v_o, itlb_fence_v_o} !== 3'b110 || itlb_w_vaddr_o !== 'h4000_1000
            || itlb_w_pte_o !== {44'h12345, 5'b00101} || redirect_pc_o !== 'h4000_1000) begin
            errors++;
            $display("FAIL itlb_fill: got %b vaddr %h pte %h pc %h", {itlb_w_v_o, redirect_v_o, itlb_fence_v_o}, itlb_w_vaddr_o, itlb_w_pte_o, redirect_pc_o);
        end
        send(mk(e_op_itlb_fence, 'h3000));
        checks++;
        if ({itlb_w_v_o, redirect_v_o, itlb_fence_v_o} !== 3'b011 || redirect_pc_o !== 'h3000) begin
            errors++;
            $display("FAIL itlb_fence: got %b pc %h want 011 pc 3000", {itlb_w_v_o, redirect_v_o, itlb_fence_v_o}, redirect_pc_o);
        end
        send(mk(e_op_icache_fill, 'h5000));
        checks++;
        if ({itlb_w_v_o, redirect_v_o, itlb_fence_v_o, icache_fence_v_o} !== 4'b0100 || redirect_pc_o !== 'h5000) begin
            errors++;
            $display("FAIL icache_fill: got %b pc %h want 0100 pc 5000", {itlb_w_v_o, redirect_v_o, itlb_fence_v_o, icache_fence_v_o}, redirect_pc_o);
        end
    endtask

    task automatic test_fence;
        bp_fe_cmd_s c;
        fe_cmd_if.fe_cmd = mk(e_op_icache_fence, 'h2000);
        fe_cmd_if.fe_cmd_v = 1'b1;
        icache_fence_done_i = 1'b1;
        tick;
        icache_fence_done_i = 1'b0;
        c = mk(e_op_attaboy, '0);
        c.attaboy_taken = 1'b1;
        c.branch_metadata_fwd = 32'h77;
        fe_cmd_if.fe_cmd = c;
        #1;
        checks++;
        if ({icache_fence_v_o, redirect_v_o, fetch_stall_o, fe_cmd_if.fe_cmd_yumi} !== 4'b1010) begin
            errors++;
            $display("FAIL fence_enter: got %b want 1010", {icache_fence_v_o, redirect_v_o, fetch_stall_o, fe_cmd_if.fe_cmd_yumi});
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if ({fe_cmd_if.fe_cmd_yumi, redirect_v_o, attaboy_v_o, fetch_stall_o} !== 4'b0001) begin
                errors++;
                $display("FAIL fence_hold_%0d: got %b want 0001", i, {fe_cmd_if.fe_cmd_yumi, redirect_v_o, attaboy_v_o, fetch_stall_o});
            end
        end
        icache_fence_done_i = 1'b1;
        tick;
        icache_fence_done_i = 1'b0;
        checks++;
        if ({redirect_v_o, fe_cmd_if.fe_cmd_yumi, attaboy_v_o} !== 3'b110 || redirect_pc_o !== 'h2000) begin
            errors++;
            $display("FAIL fence_redirect: got %b pc %h want 110 pc 2000", {redirect_v_o, fe_cmd_if.fe_cmd_yumi, attaboy_v_o}, redirect_pc_o);
        end
        tick;
        fe_cmd_if.fe_cmd_v = 1'b0;
        checks++;
        if ({attaboy_v_o, attaboy_taken_o, redirect_v_o} !== 3'b110 || attaboy_br_metadata_fwd_o !== 32'h77) begin
            errors++;
            $display("FAIL fence_second_cmd: got %b md %h want 110 md 77", {attaboy_v_o, attaboy_taken_o, redirect_v_o}, attaboy_br_metadata_fwd_o);
        end
        icache_fence_done_i = 1'b1;
        tick;
        icache_fence_done_i = 1'b0;
        checks++;
        if (redirect_v_o !== 1'b0) begin
            errors++;
            $display("FAIL stray_done_in_run: got %b want 0", redirect_v_o);
        end
    endtask

    task automatic test_wait;
        bp_fe_cmd_s c;
        c = mk(e_op_pc_redirection, 'h300);
        c.subopcode = e_subop_resume;
        c.priv = 2'b00;
        c.translation_en = 1'b1;
        send(c);
        send(mk(e_op_wait, '0));
        checks++;
        if ({redirect_v_o, fetch_stall_o} !== 2'b01 || dut.state_q !== e_wait) begin
            errors++;
            $display("FAIL wait_enter: got %b state %0d want 01 state %0d", {redirect_v_o, fetch_stall_o}, dut.state_q, e_wait);
        end
        tick;
        c = mk(e_op_pc_redirection, 'h80);
        c.subopcode = e_subop_interrupt;
        c.priv = 2'b11;
        c.translation_en = 1'b0;
        fe_cmd_if.fe_cmd = c;
        fe_cmd_if.fe_cmd_v = 1'b1;
        #1;
        checks++;
        if ({fetch_stall_o, fe_cmd_if.fe_cmd_yumi} !== 2'b11) begin
            errors++;
            $display("FAIL wait_hold: got %b want 11", {fetch_stall_o, fe_cmd_if.fe_cmd_yumi});
        end
        tick;
        fe_cmd_if.fe_cmd_v = 1'b0;
        checks++;
        if ({redirect_v_o, priv_o, translation_en_o, fetch_stall_o} !== 5'b11101 || redirect_pc_o !== 'h80) begin
            errors++;
            $display("FAIL wait_interrupt: got %b pc %h want 11101 pc 80", {redirect_v_o, priv_o, translation_en_o, fetch_stall_o}, redirect_pc_o);
        end
        tick;
        checks++;
        if (fetch_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL wait_resume_fetch: got %b want 0", fetch_stall_o);
        end
    endtask

    task automatic test_reset_mid;
        bp_fe_cmd_s c;
        c = mk(e_op_itlb_fill, 'h4000_1000);
        c.pte_leaf.ptag = 44'hABC;
        send(c);
        checks++;
        if (itlb_w_v_o !== 1'b1 || itlb_w_vaddr_o !== 'h4000_1000) begin
            errors++;
            $display("FAIL reset_mid_itlb: got %b vaddr %h want 1 vaddr 40001000", itlb_w_v_o, itlb_w_vaddr_o);
        end
        fe_cmd_if.fe_cmd = mk(e_op_icache_fence, 'h6000);
        fe_cmd_if.fe_cmd_v = 1'b1;
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
        fe_cmd_if.fe_cmd_v = 1'b0;
        checks++;
        if ({icache_fence_v_o, itlb_w_v_o, redirect_v_o, priv_o, fetch_stall_o} !== 6'b000111 || dut.state_q !== e_reset) begin
            errors++;
            $display("FAIL reset_mid_fence: got %b state %0d want 000111 state %0d", {icache_fence_v_o, itlb_w_v_o, redirect_v_o, priv_o, fetch_stall_o}, dut.state_q, e_reset);
        end
        icache_fence_done_i = 1'b1;
        tick;
        icache_fence_done_i = 1'b0;
        checks++;
        if ({redirect_v_o, redirect_pc_o} !== {1'b0, {vaddr_width_gp{1'b0}}}) begin
            errors++;
            $display("FAIL reset_mid_done_ignored: got %b pc %h want 0 pc 0", redirect_v_o, redirect_pc_o);
        end
    endtask

    initial begin
        fe_cmd_if.fe_cmd = '0;
        fe_cmd_if.fe_cmd_v = 1'b0;
        test_reset;
        test_drop_in_reset;
        test_state_reset;
        test_priv;
        test_mispredict;
        test_back_to_back;
        test_itlb;
        test_fence;
        test_wait;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
